// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the instruction-cache controller.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_REFILL,
    S_RESPOND,
    S_FLUSH
  } state_t;

  function automatic int clog2i(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_WORDS = 4;
  localparam int DEF_SETS  = 64;
  localparam int OW = clog2i(DEF_WORDS);
  localparam int IW = clog2i(DEF_SETS);

  // Word-in-line field: addr[ow+1:2]
  function automatic logic [31:0] word_of(input logic [31:0] a, input int ow);
    return (a >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  // Line index field: addr[iw+ow+1:ow+2]
  function automatic logic [31:0] index_of(input logic [31:0] a, input int ow, input int iw);
    return (a >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_refill_cnt.sv
// Refill beat counter: latches the critical (start) word and walks the line with natural OW-bit wrap.
module icache_refill_cnt #(
  parameter  int WORDS = 4,
  localparam int OW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [OW-1:0] start_word,
  input  logic          beat,
  output logic [OW-1:0] word,
  output logic          last
);

  logic [OW-1:0] cnt;
  logic [OW-1:0] start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (start) cnt <= '0;
    else if (beat)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (start) start_q <= start_word;
  end

  assign word = start_q + cnt;
  assign last = (cnt == OW'(WORDS - 1));

endmodule

// File: rtl/icache_ctrl_p.sv
// Parametrised I-cache controller with critical-word-first refill and flush walker.
// Performance counters are built only when ICACHE_PERF_EN is defined.
module icache_ctrl_p
  import icache_pkg::*;
#(
  parameter  int AW     = 32,
  parameter  int WORDS  = 4,
  parameter  int SETS   = 64,
  parameter  int PERF_W = 32,
  localparam int OW     = clog2i(WORDS),
  localparam int IW     = clog2i(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     addr,
  input  logic              req,
  input  logic              hit,
  input  logic              flush,
  input  logic              mem_ready,
  input  logic              mem_hold,
  output logic              tag_cs,
  output logic              tag_oe,
  output logic              tag_web,
  output logic [IW-1:0]     tag_idx,
  output logic              tag_vld_wr,
  output logic [WORDS-1:0]  data_cs,
  output logic              data_oe,
  output logic [WORDS-1:0]  data_web,
  output logic              stall,
  output logic              instr_valid,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic              flush_busy,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt
);

  state_t        state, state_nx;
  logic          flush_pend;
  logic [IW-1:0] fidx;
  logic [OW-1:0] word;
  logic [IW-1:0] idx;
  logic [OW-1:0] beat_word;
  logic          last_beat;
  logic          beat_ok;
  logic          refill_start;

  function automatic logic [WORDS-1:0] onehot(input logic [OW-1:0] w);
    logic [WORDS-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  assign word         = OW'(word_of(32'(addr), OW));
  assign idx          = IW'(index_of(32'(addr), OW, IW));
  assign beat_ok      = (state == S_REFILL) && mem_ready && !mem_hold;
  assign refill_start = (state == S_COMPARE) && !hit;

  icache_refill_cnt #(.WORDS(WORDS)) u_refill_cnt (
    .clk        (clk),
    .rst        (rst),
    .start      (refill_start),
    .start_word (word),
    .beat       (beat_ok),
    .word       (beat_word),
    .last       (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // A flush that lands mid-access is remembered and serviced from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_pend <= 1'b0;
    else if (state == S_FLUSH && fidx == IW'(SETS - 1))
      flush_pend <= 1'b0;
    else if (flush && state != S_IDLE && state != S_FLUSH)
      flush_pend <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  fidx <= '0;
    else if (state == S_FLUSH) fidx <= fidx + 1'b1;
    else                      fidx <= '0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (flush || flush_pend) state_nx = S_FLUSH;
                 else if (req)            state_nx = S_LOOKUP;
      S_LOOKUP:  state_nx = S_COMPARE;
      S_COMPARE: state_nx = hit ? S_RESPOND : S_REFILL;
      S_REFILL:  if (beat_ok && last_beat) state_nx = S_RESPOND;
      S_RESPOND: state_nx = S_IDLE;
      S_FLUSH:   if (fidx == IW'(SETS - 1)) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tag_cs      = 1'b0;
    tag_oe      = 1'b0;
    tag_web     = 1'b1;
    tag_idx     = '0;
    tag_vld_wr  = 1'b0;
    data_cs     = '0;
    data_oe     = 1'b0;
    data_web    = '1;
    stall       = 1'b0;
    instr_valid = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    flush_busy  = 1'b0;
    unique case (state)
      S_IDLE:    stall = req && !rst;
      S_LOOKUP: begin
        tag_cs  = 1'b1;
        tag_oe  = 1'b1;
        tag_idx = idx;
        stall   = 1'b1;
      end
      S_COMPARE: stall = 1'b1;
      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr[AW-1:OW+2], beat_word, 2'b00};
        data_cs  = onehot(beat_word);
        if (beat_ok) data_web = ~onehot(beat_word);
        // Tag becomes valid only with the final beat, so an aborted refill leaves the line invalid
        if (beat_ok && last_beat) begin
          tag_cs     = 1'b1;
          tag_web    = 1'b0;
          tag_vld_wr = 1'b1;
          tag_idx    = idx;
        end
      end
      S_RESPOND: begin
        data_cs     = onehot(word);
        data_oe     = 1'b1;
        instr_valid = 1'b1;
      end
      S_FLUSH: begin
        tag_cs     = 1'b1;
        tag_web    = 1'b0;
        tag_idx    = fidx;
        flush_busy = 1'b1;
        stall      = req;
      end
      default: ;
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [PERF_W-1:0] hit_q, miss_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == S_COMPARE) begin
      if (hit) hit_q  <= sat_inc(hit_q);
      else     miss_q <= sat_inc(miss_q);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
